nv_gated_res_arb: RTL and testbench
===================================

NV_GATED_RES_ARB -- requirements
Module: nv_gated_res_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (legal 2..16).
REQ-002 The block SHALL have parameter WARMUP, default 2, giving the cycles the gate enable is held before the first grant (legal >= 1).
REQ-003 The block SHALL have parameter IDLE_HOLD, default 8, giving the consecutive idle cycles before the gate enable drops (legal >= 1).
REQ-004 nvdla_core_clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 nvdla_core_rstn  input  1  asynchronous active-low reset.
REQ-006 req  input  NUM_REQ  level request per requester to use the shared gated resource.
REQ-007 done  input  NUM_REQ  one-cycle release pulse from the granted requester.
REQ-008 gnt  output  NUM_REQ  registered one-hot grant, or all zeros.
REQ-009 gate_en  output  1  registered enable for the resource's AND-type clock/power gate.
REQ-010 busy  output  1  high whenever state is not OFF.

Function
REQ-011 The FSM SHALL have states OFF, WARM, ON and GNT; all outputs SHALL be driven from registers.
REQ-012 OFF: gate_en=0, gnt=0; if any req bit is high, go to WARM next cycle and load warm counter with WARMUP.
REQ-013 WARM: gate_en=1, gnt=0; stay exactly WARMUP cycles; on the last one, go to GNT if any req is high, else go to ON.
REQ-014 ON: gate_en=1, gnt=0; if any req is high, go to GNT next cycle.
REQ-015 ON with req all zero: the idle counter SHALL increment, and when IDLE_HOLD consecutive idle cycles have elapsed, the FSM SHALL go to OFF.
REQ-016 The idle counter SHALL clear on every ON entry and on every cycle where any req is high.
REQ-017 Expiry/request collision: if req is high in the expiry cycle, the request SHALL win and the FSM SHALL go to GNT, not OFF.
REQ-018 On entry to GNT, the winner SHALL be the first set req bit at or after the rotating pointer, searching upward with modulo-NUM_REQ wrap-around; gnt SHALL be its one-hot value.
REQ-019 GNT: gate_en=1; gnt SHALL be held constant until done[i] is seen with gnt[i]=1.
REQ-020 On a valid done, gnt SHALL go to zero the next cycle, the FSM SHALL go to ON, and the pointer SHALL become (winner+1) mod NUM_REQ.
REQ-021 After a valid done, at least one gnt=0 cycle SHALL separate consecutive grants.
REQ-022 The granted requester dropping req while granted SHALL NOT release the grant; only done releases it.
REQ-023 A done bit without a matching gnt bit SHALL be ignored in every state.
REQ-024 Latency: a req first sampled in OFF at cycle t SHALL give gate_en=1 at t+1 and gnt at t+1+WARMUP.
REQ-025 Latency: a req sampled in ON at cycle t SHALL give gnt at t+1.
REQ-026 gate_en SHALL be 1 in every cycle in which gnt is non-zero.
REQ-027 Counter widths SHALL be sized from the parameters so that no count wraps.

Reset
REQ-028 While nvdla_core_rstn=0, the block SHALL immediately force state=OFF, gnt=0, gate_en=0, busy=0, pointer=0 and both counters=0, regardless of the clock.
REQ-029 Reset asserted in any state, including GNT and WARM, SHALL abort the operation with no residual grant after reset release.
REQ-030 After reset release, the first req SHALL follow the OFF->WARM timing of REQ-024.

Verification (NUM_REQ=4, WARMUP=2, IDLE_HOLD=8)
REQ-031 Cold grant and idle shutdown: req=0010 from cycle 0 in OFF, done=0010 at cycle 5, req=0 after cycle 5 -> gate_en=1 at cycle 1, gnt=0010 at cycles 3-5, gnt=0 at cycle 6, gate_en=0 from cycle 14.
REQ-032 Round-robin fairness: req=1111 held, each grant released by done one cycle after grant -> grant sequence 0001, 0010, 0100, 1000, 0001, each separated by one gnt=0 cycle.
REQ-033 Release rules: done=0100 during gnt=0001 -> gnt unchanged; req[0] dropped during gnt=0001 -> gnt still 0001 until done=0001.
REQ-034 Expiry collision: in ON, req=1000 asserted exactly in the 8th idle cycle -> gate_en stays 1 and gnt=1000 next cycle.
REQ-035 Reset mid-grant: nvdla_core_rstn driven low mid-cycle while gnt=0100 -> gnt=0000 and gate_en=0 before the next clock edge; a req=0001 after release is granted at t+3.

Source files
------------

// File: rtl/nv_gated_res_arb.sv
// Round-robin arbiter for a shared, clock/power-gated resource: wakes the gate,
// waits a warm-up period, grants one requester at a time and drops the gate after idling.
module nv_gated_res_arb #(
  parameter int NUM_REQ   = 4,
  parameter int WARMUP    = 2,
  parameter int IDLE_HOLD = 8
) (
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rstn,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gate_en,
  output logic               busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int WW = $clog2(WARMUP + 1);
  localparam int IW = $clog2(IDLE_HOLD + 1);

  typedef enum logic [1:0] {ST_OFF, ST_WARM, ST_ON, ST_GNT} state_t;

  state_t             state_reg, state_next;
  logic [WW-1:0]      warm_cnt_reg, warm_cnt_next;
  logic [IW-1:0]      idle_cnt_reg, idle_cnt_next;
  logic [PW-1:0]      ptr_reg, ptr_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic               gate_en_reg, gate_en_next;
  logic               busy_reg, busy_next;

  logic any_req, done_valid, warm_last, idle_expire;

  assign any_req     = |req;
  assign done_valid  = (state_reg == ST_GNT) && (|(done & gnt_reg));
  assign warm_last   = (warm_cnt_reg == WW'(1));
  assign idle_expire = (idle_cnt_reg == IW'(IDLE_HOLD - 1));

  // Rotate requests so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
  logic [NUM_REQ-1:0] req_rot, lsb_rot, win_onehot;
  logic [PW:0]        rot_back;

  assign req_rot    = NUM_REQ'({req, req} >> ptr_reg);
  assign lsb_rot    = req_rot & (~req_rot + NUM_REQ'(1));
  assign rot_back   = (PW + 1)'(NUM_REQ) - {1'b0, ptr_reg};
  assign win_onehot = NUM_REQ'({lsb_rot, lsb_rot} >> rot_back);

  // Binary index of the current grant, used to advance the pointer past the winner.
  logic [PW-1:0] gnt_idx;

  genvar gi, gj;
  generate
    for (gj = 0; gj < PW; gj++) begin : g_enc
      logic [NUM_REQ-1:0] sel_mask;
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_bit
        assign sel_mask[gi] = (((gi >> gj) & 1) != 0);
      end
      assign gnt_idx[gj] = |(gnt_reg & sel_mask);
    end
  endgenerate

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_reg    <= ST_OFF;
      warm_cnt_reg <= '0;
      idle_cnt_reg <= '0;
      ptr_reg      <= '0;
      gnt_reg      <= '0;
      gate_en_reg  <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      warm_cnt_reg <= warm_cnt_next;
      idle_cnt_reg <= idle_cnt_next;
      ptr_reg      <= ptr_next;
      gnt_reg      <= gnt_next;
      gate_en_reg  <= gate_en_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_OFF:  if (any_req) state_next = ST_WARM;
      ST_WARM: if (warm_last) state_next = any_req ? ST_GNT : ST_ON;
      // A request arriving in the expiry cycle wins over shutdown.
      ST_ON: begin
        if (any_req)          state_next = ST_GNT;
        else if (idle_expire) state_next = ST_OFF;
      end
      ST_GNT:  if (done_valid) state_next = ST_ON;
      default: state_next = ST_OFF;
    endcase
  end

  always_comb begin
    gate_en_next = (state_next != ST_OFF);
    busy_next    = (state_next != ST_OFF);

    gnt_next = '0;
    if (state_next == ST_GNT)
      gnt_next = (state_reg == ST_GNT) ? gnt_reg : win_onehot;

    warm_cnt_next = '0;
    if (state_reg == ST_OFF && any_req)
      warm_cnt_next = WW'(WARMUP);
    else if (state_reg == ST_WARM && !warm_last)
      warm_cnt_next = warm_cnt_reg - WW'(1);

    // Idle count restarts on ON entry and whenever a request leaves ON.
    idle_cnt_next = '0;
    if (state_reg == ST_ON && state_next == ST_ON)
      idle_cnt_next = idle_cnt_reg + IW'(1);

    ptr_next = ptr_reg;
    if (done_valid)
      ptr_next = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
  end

  assign gnt     = gnt_reg;
  assign gate_en = gate_en_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_nv_gated_res_arb.sv
// Scoreboard bench for nv_gated_res_arb: per-cycle expectations are queued as stimulus
// is planned and compared on the falling edge of the matching cycle.
module tb_nv_gated_res_arb;

  localparam int N = 4;

  logic         nvdla_core_clk  = 1'b0;
  logic         nvdla_core_rstn = 1'b1;
  logic [N-1:0] req  = '0;
  logic [N-1:0] done = '0;
  logic [N-1:0] gnt;
  logic         gate_en;
  logic         busy;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int           cyc;
    logic [63:0]  tag;
    logic [N-1:0] gnt;
    logic         gate;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  nv_gated_res_arb #(.NUM_REQ(N), .WARMUP(2), .IDLE_HOLD(8)) dut (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rstn(nvdla_core_rstn),
    .req            (req),
    .done           (done),
    .gnt            (gnt),
    .gate_en        (gate_en),
    .busy           (busy)
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  always @(posedge nvdla_core_clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s val=%0h", tag, got);
    end
  endtask

  task automatic expect_at(input int c, input logic [63:0] tag, input logic [N-1:0] g,
                           input logic ge);
    exp_t e;
    e.cyc  = c;
    e.tag  = tag;
    e.gnt  = g;
    e.gate = ge;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge nvdla_core_clk);
    #1;
  endtask

  always @(negedge nvdla_core_clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc != cyc) begin
        check_val($sformatf("%0s_missed", mon_e.tag), cyc, mon_e.cyc);
      end else begin
        check_val($sformatf("%0s_gnt@%0d", mon_e.tag, cyc), int'(gnt), int'(mon_e.gnt));
        check_val($sformatf("%0s_gate@%0d", mon_e.tag, cyc), int'(gate_en), int'(mon_e.gate));
        check_val($sformatf("%0s_busy@%0d", mon_e.tag, cyc), int'(busy), int'(mon_e.gate));
      end
    end
  end

  initial begin
    int c0;
    logic [N-1:0] g;

    // Power-on reset, checked before any clock edge.
    #1 nvdla_core_rstn = 1'b0;
    #1;
    check_val("por_gnt", int'(gnt), 0);
    check_val("por_gate", int'(gate_en), 0);
    check_val("por_busy", int'(busy), 0);
    tick();
    tick();
    nvdla_core_rstn = 1'b1;
    expect_at(cyc, "release", '0, 1'b0);
    tick();

    // Cold grant then idle shutdown.
    c0 = cyc;
    for (int k = 0; k <= 15; k++) begin
      g = (k >= 3 && k <= 5) ? 4'b0010 : 4'b0000;
      expect_at(c0 + k, "cold", g, (k >= 1 && k <= 13));
    end
    for (int k = 0; k <= 15; k++) begin
      req  = (k <= 5) ? 4'b0010 : 4'b0000;
      done = (k == 5) ? 4'b0010 : 4'b0000;
      tick();
    end

    // Reset between operations so the pointer restarts at requester 0.
    #1 nvdla_core_rstn = 1'b0;
    tick();
    nvdla_core_rstn = 1'b1;
    tick();

    // Round-robin with all requesters active.
    c0 = cyc;
    for (int k = 0; k <= 17; k++) begin
      g = '0;
      if (k >= 3 && k <= 16 && ((k - 3) % 3) != 2)
        g = N'(1 << (((k - 3) / 3) % 4));
      expect_at(c0 + k, "rr", g, (k >= 1));
    end
    for (int k = 0; k <= 17; k++) begin
      req  = (k <= 16) ? 4'b1111 : 4'b0000;
      done = '0;
      if (k >= 4 && k <= 16 && ((k - 4) % 3) == 0)
        done = N'(1 << (((k - 4) / 3) % 4));
      tick();
    end

    // Release rules, then a request colliding with the 8th idle cycle.
    c0 = cyc;
    for (int k = 0; k <= 14; k++) begin
      g = '0;
      if (k >= 1 && k <= 4) g = 4'b0001;
      if (k == 13)          g = 4'b1000;
      expect_at(c0 + k, "rel_exp", g, 1'b1);
    end
    for (int k = 0; k <= 14; k++) begin
      req = '0;
      if (k <= 1)  req = 4'b0001;
      if (k == 12) req = 4'b1000;
      done = '0;
      if (k == 0)  done = 4'b1000;
      if (k == 1)  done = 4'b0100;
      if (k == 4)  done = 4'b0001;
      if (k == 13) done = 4'b1000;
      tick();
    end

    // Asynchronous reset in the middle of a grant.
    c0 = cyc;
    done = '0;
    expect_at(c0, "rstmid", '0, 1'b1);
    expect_at(c0 + 1, "rstmid", 4'b0100, 1'b1);
    req = 4'b0100;
    tick();
    tick();
    #2 nvdla_core_rstn = 1'b0;
    #1;
    check_val("rstmid_async_gnt", int'(gnt), 0);
    check_val("rstmid_async_gate", int'(gate_en), 0);
    check_val("rstmid_async_busy", int'(busy), 0);
    req = '0;
    tick();
    tick();
    nvdla_core_rstn = 1'b1;
    done = 4'b0001;
    expect_at(cyc, "postrst", '0, 1'b0);
    tick();

    c0 = cyc;
    expect_at(c0,     "postrst", '0, 1'b0);
    expect_at(c0 + 1, "postrst", '0, 1'b1);
    expect_at(c0 + 2, "postrst", '0, 1'b1);
    expect_at(c0 + 3, "postrst", 4'b0001, 1'b1);
    expect_at(c0 + 4, "postrst", '0, 1'b1);
    for (int k = 0; k <= 4; k++) begin
      req  = (k <= 3) ? 4'b0001 : 4'b0000;
      done = (k == 3) ? 4'b0001 : 4'b0000;
      tick();
    end
    req  = '0;
    done = '0;
    tick();
    tick();

    check_val("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
